axi_read_slave_fsm: RTL and testbench
=====================================

// Module: axi_read_slave_fsm
// PURPOSE
//  AXI4 read-channel responder: the read-direction counterpart of the write-channel master/slave pair.
//  Accepts one AR request at a time, generates burst beat addresses (FIXED/INCR/WRAP) and fetches each beat
//  from a synchronous 1-cycle-latency memory port. Returns beats on R with RID/RRESP/RLAST, honouring RREADY
//  backpressure; sits between the AXI interconnect slave port and a local SRAM.
// PARAMETERS
//  IDW  12  transaction ID width
//  AW   32  address width (byte address)
//  DW   64  data width; max legal arsize = log2(DW/8) = 3
// PORTS
//  clk              in   1     clock; all logic rising-edge
//  rst              in   1     asynchronous, active-high reset
//  s_axi_arid       in   IDW   read ID
//  s_axi_araddr     in   AW    start byte address
//  s_axi_arlen      in   8     beats-1
//  s_axi_arsize     in   3     log2(bytes per beat)
//  s_axi_arburst    in   2     00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//  s_axi_arvalid    in   1     AR valid
//  s_axi_arready    out  1     AR ready
//  s_axi_rid        out  IDW   echoed ARID
//  s_axi_rdata      out  DW    read data
//  s_axi_rresp      out  2     00 OKAY, 10 SLVERR
//  s_axi_rlast      out  1     final beat of burst
//  s_axi_rvalid     out  1     R valid
//  s_axi_rready     in   1     R ready
//  mem_rd_en        out  1     memory read strobe (1 cycle per beat)
//  mem_rd_addr      out  AW    beat byte address
//  mem_rd_data      in   DW    valid the cycle after mem_rd_en
//  busy             out  1     high whenever state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; arready=0 while rst high, 1 the first cycle after release; rvalid, rlast, mem_rd_en=0;
//   rdata, rid, rresp, mem_rd_addr=0; busy=0. rst mid-burst aborts immediately: no further beats, R drops.
//  States: IDLE -> FETCH -> LOAD -> RESP -> (FETCH | IDLE); ERR_RESP used for error bursts.
//  IDLE: arready=1. On arvalid&arready latch id/addr/len/size/burst, beat counter = len.
//   Error check: burst==11, or arsize>log2(DW/8), or WRAP with len not in {1,3,7,15} -> ERR_RESP; else -> FETCH.
//  FETCH: mem_rd_en=1, mem_rd_addr = current beat address; -> LOAD.
//  LOAD: register mem_rd_data into rdata, rresp=00, rlast=(counter==0); -> RESP with rvalid=1.
//  RESP: rvalid held high, rdata/rid/rresp/rlast stable until rready. On rvalid&rready: if rlast -> IDLE,
//   else decrement counter, advance address -> FETCH. Latency AR handshake to first rvalid = 3 cycles;
//   steady state 1 beat per 3 cycles with rready tied high.
//  ERR_RESP: no memory reads; presents len+1 beats, rdata=0, rresp=10, rlast on final beat, same handshake.
//  Address update (per accepted beat), bytes = 1<<size:
//   FIXED: unchanged. INCR: addr+bytes, modulo 2^AW (wraps silently at top).
//   WRAP: span=(len+1)*bytes, base=addr & ~(span-1); next=addr+bytes; if next==base+span then next=base.
//   First beat uses unaligned araddr as given; mem_rd_addr passes it unmodified.
//  arready is 0 outside IDLE; no AR accepted until last R beat handshakes (single outstanding).
//  Simultaneous AR accept and R last handshake cannot occur (arready low in RESP).
//  rvalid never deasserts without a handshake except on rst.
// TESTING
//  1 INCR: araddr=0x100,len=3,size=3,id=5, rready=1 -> mem_rd_addr 0x100,0x108,0x110,0x118; 4 beats id=5 OKAY, rlast on 4th only.
//  2 WRAP: araddr=0x38,len=3,size=3 -> addresses 0x38,0x20,0x28,0x30; rlast on 4th beat.
//  3 Backpressure: rready low 5 cycles on beat 2 -> rvalid/rdata stable, no mem_rd_en until handshake.
//  4 Error: arburst=11,len=2 -> 3 beats rresp=10,rdata=0, mem_rd_en never asserted; WRAP len=2 also SLVERR.
//  5 FIXED len=2 addr=0x40 -> three reads of 0x40; INCR from 0xFFFF_FFF8 size=3 -> second addr 0x0.
//  6 rst pulse during beat 2 RESP -> rvalid=0 at once; after release arready=1, next AR served normally.

Source files
------------

// File: rtl/axi_read_slave_fsm.sv
// AXI4 read-channel responder: one outstanding AR, FIXED/INCR/WRAP beat address generation,
// each beat fetched from a 1-cycle-latency synchronous memory port and returned on R.
module axi_read_slave_fsm #(
  parameter int IDW = 12,
  parameter int AW  = 32,
  parameter int DW  = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [IDW-1:0] s_axi_arid,
  input  logic [AW-1:0]  s_axi_araddr,
  input  logic [7:0]     s_axi_arlen,
  input  logic [2:0]     s_axi_arsize,
  input  logic [1:0]     s_axi_arburst,
  input  logic           s_axi_arvalid,
  output logic           s_axi_arready,
  output logic [IDW-1:0] s_axi_rid,
  output logic [DW-1:0]  s_axi_rdata,
  output logic [1:0]     s_axi_rresp,
  output logic           s_axi_rlast,
  output logic           s_axi_rvalid,
  input  logic           s_axi_rready,
  output logic           mem_rd_en,
  output logic [AW-1:0]  mem_rd_addr,
  input  logic [DW-1:0]  mem_rd_data,
  output logic           busy
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DW/8));

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_RESP,
    S_ERR_RESP
  } state_t;

  state_t        state;
  logic [AW-1:0] addr_q;
  logic [7:0]    len_q;
  logic [7:0]    cnt_q;
  logic [2:0]    size_q;
  logic [1:0]    burst_q;

  logic [AW-1:0] bytes;
  logic [AW-1:0] span;
  logic [AW-1:0] base;
  logic [AW-1:0] incr;
  logic [AW-1:0] next_addr;
  logic          ar_err;
  logic          ar_fire;
  logic          r_fire;

  // Valid/ready: a transfer happens on any rising edge where valid and ready are both high;
  // valid, once raised, is held with its payload stable until that transfer (only rst drops it).
  assign ar_fire = s_axi_arvalid && s_axi_arready;
  assign r_fire  = s_axi_rvalid && s_axi_rready;
  assign busy    = (state != S_IDLE);

  assign ar_err = (s_axi_arburst == 2'b11) ||
                  (s_axi_arsize > MAX_SIZE) ||
                  ((s_axi_arburst == 2'b10) && !(s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

  always_comb begin
    bytes     = AW'(1) << size_q;
    span      = ({{(AW-8){1'b0}}, len_q} + AW'(1)) << size_q;
    base      = addr_q & ~(span - AW'(1));
    incr      = addr_q + bytes;
    next_addr = addr_q;
    case (burst_q)
      2'b01:   next_addr = incr;
      2'b10:   next_addr = (incr == base + span) ? base : incr;
      default: next_addr = addr_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rid     <= '0;
      s_axi_rresp   <= 2'b00;
      mem_rd_en     <= 1'b0;
      mem_rd_addr   <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      size_q        <= '0;
      burst_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          s_axi_arready <= 1'b1;
          if (ar_fire) begin
            s_axi_arready <= 1'b0;
            s_axi_rid     <= s_axi_arid;
            addr_q        <= s_axi_araddr;
            len_q         <= s_axi_arlen;
            cnt_q         <= s_axi_arlen;
            size_q        <= s_axi_arsize;
            burst_q       <= s_axi_arburst;
            if (ar_err) begin
              // Error bursts skip memory entirely and present SLVERR beats straight away.
              state        <= S_ERR_RESP;
              s_axi_rvalid <= 1'b1;
              s_axi_rdata  <= '0;
              s_axi_rresp  <= 2'b10;
              s_axi_rlast  <= (s_axi_arlen == 8'd0);
            end else begin
              state       <= S_FETCH;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= s_axi_araddr;
            end
          end
        end
        S_FETCH: begin
          mem_rd_en <= 1'b0;
          state     <= S_LOAD;
        end
        S_LOAD: begin
          s_axi_rdata  <= mem_rd_data;
          s_axi_rresp  <= 2'b00;
          s_axi_rlast  <= (cnt_q == 8'd0);
          s_axi_rvalid <= 1'b1;
          state        <= S_RESP;
        end
        S_RESP: begin
          if (r_fire) begin
            s_axi_rvalid <= 1'b0;
            if (s_axi_rlast) begin
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              state         <= S_IDLE;
            end else begin
              cnt_q       <= cnt_q - 8'd1;
              addr_q      <= next_addr;
              mem_rd_addr <= next_addr;
              mem_rd_en   <= 1'b1;
              state       <= S_FETCH;
            end
          end
        end
        S_ERR_RESP: begin
          if (r_fire) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              state         <= S_IDLE;
            end else begin
              cnt_q       <= cnt_q - 8'd1;
              s_axi_rlast <= (cnt_q == 8'd1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_slave_fsm.sv
// Bench for axi_read_slave_fsm: directed vector table, hand-written reset/backpressure
// sequences, and random bursts scored against a burst-level reference model.
module tb_axi_read_slave_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [11:0] rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        mem_rd_en;
  logic [31:0] mem_rd_addr;
  logic [63:0] mem_rd_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Expected beats packed as {id[78:67], resp[66:65], last[64], data[63:0]}.
  logic [78:0] exp_q[$];
  logic [78:0] got_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] got_addr_q[$];

  axi_read_slave_fsm dut (
    .clk(clk), .rst(rst),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'h5A5A_0F0F, ~a};
  endfunction

  // Memory model: data valid only in the cycle after the read strobe, garbage otherwise.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem_word(mem_rd_addr);
    else           mem_rd_data <= 64'hDEAD_BEEF_DEAD_BEEF;
  end

  always @(negedge clk) begin
    if (mem_rd_en) got_addr_q.push_back(mem_rd_addr);
  end

  task automatic check(input string name, input logic [78:0] act, input logic [78:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: list every beat of the burst from the AXI rules directly.
  function automatic logic is_err(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic bad_wrap;
    bad_wrap = (burst == 2'b10) && !(len == 1 || len == 3 || len == 7 || len == 15);
    return (burst == 2'b11) || (size > 3) || bad_wrap;
  endfunction

  task automatic build_expect(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
    longint unsigned bytes, span, base, a;
    bytes = 64'd1 << size;
    span  = (longint'(len) + 1) * bytes;
    base  = (longint'(addr) / span) * span;
    for (int i = 0; i <= int'(len); i++) begin
      if (is_err(len, size, burst)) begin
        exp_q.push_back({id, 2'b10, (i == int'(len)), 64'h0});
      end else begin
        case (burst)
          2'b00:   a = addr;
          2'b01:   a = (longint'(addr) + longint'(i) * bytes) % 64'h1_0000_0000;
          default: a = base + ((longint'(addr) - base + longint'(i) * bytes) % span);
        endcase
        exp_addr_q.push_back(a[31:0]);
        exp_q.push_back({id, 2'b00, (i == int'(len)), mem_word(a[31:0])});
      end
    end
  endtask

  // mode 0: rready high; 1: random rready; 2: hold rready low 5 cycles on beat 2.
  task automatic run_burst(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode);
    int cyc, edges, beat, stall;
    logic seen, done, ok;
    logic [63:0] held;
    got_q.delete();
    got_addr_q.delete();
    exp_q.delete();
    exp_addr_q.delete();
    build_expect(id, addr, len, size, burst);
    ok = !is_err(len, size, burst);
    cyc = 0;
    while (!arready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("ar_wait", {78'b0, arready}, 79'd1);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    arid = 12'($urandom); araddr = $urandom; arlen = 8'($urandom);
    edges = 1; beat = 0; stall = (mode == 2) ? 5 : 0; seen = 1'b0; done = 1'b0; cyc = 0;
    while (!done && cyc < 3000) begin
      if (rvalid && !seen) begin
        seen = 1'b1;
        check("first_latency", 79'(edges), ok ? 79'd3 : 79'd1);
      end
      if (mode == 2 && beat == 1 && stall > 0 && (stall < 5 || rvalid)) begin
        if (stall == 5) held = rdata;
        rready = 1'b0;
        check("stall_rvalid", {78'b0, rvalid}, 79'd1);
        check("stall_rdata", {15'b0, rdata}, {15'b0, held});
        check("stall_no_read", {78'b0, mem_rd_en}, 79'd0);
        stall--;
      end else if (mode == 1) begin
        rready = ($urandom_range(0, 9) < 7);
      end else begin
        rready = 1'b1;
      end
      if (rvalid && rready) begin
        got_q.push_back({rid, rresp, rlast, rdata});
        if (exp_q.size() == 0) check("extra_beat", {rid, rresp, rlast, rdata}, 79'd0);
        else check("beat", {rid, rresp, rlast, rdata}, exp_q.pop_front());
        check("busy_in_burst", {78'b0, busy}, 79'd1);
        beat++;
        if (rlast) done = 1'b1;
      end
      if (!done) begin
        @(negedge clk);
        edges++;
        cyc++;
      end
    end
    check("burst_finished", {78'b0, done}, 79'd1);
    rready = 1'b1;
    @(negedge clk);
    check("idle_arready", {78'b0, arready}, 79'd1);
    check("idle_busy", {78'b0, busy}, 79'd0);
    check("missing_beats", 79'(exp_q.size()), 79'd0);
    check("read_count", 79'(got_addr_q.size()), 79'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size() && i < got_addr_q.size(); i++)
      check("read_addr", {47'b0, got_addr_q[i]}, {47'b0, exp_addr_q[i]});
  endtask

  typedef struct {
    logic [11:0] id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          mode;
    int          exp_beats;
    logic [1:0]  exp_resp;
    int          exp_reads;
    logic [31:0] exp_a1;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{12'd5,  32'h0000_0100, 8'd3, 3'd3, 2'b01, 0, 4, 2'b00, 4, 32'h0000_0108};
    vecs[1] = '{12'd6,  32'h0000_0038, 8'd3, 3'd3, 2'b10, 0, 4, 2'b00, 4, 32'h0000_0020};
    vecs[2] = '{12'd7,  32'h0000_0200, 8'd3, 3'd3, 2'b01, 2, 4, 2'b00, 4, 32'h0000_0208};
    vecs[3] = '{12'd8,  32'h0000_0500, 8'd2, 3'd3, 2'b11, 0, 3, 2'b10, 0, 32'h0};
    vecs[4] = '{12'd9,  32'h0000_0600, 8'd2, 3'd3, 2'b10, 0, 3, 2'b10, 0, 32'h0};
    vecs[5] = '{12'd10, 32'h0000_0040, 8'd2, 3'd3, 2'b00, 0, 3, 2'b00, 3, 32'h0000_0040};
    vecs[6] = '{12'd11, 32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01, 0, 2, 2'b00, 2, 32'h0000_0000};
    vecs[7] = '{12'd12, 32'h0000_0700, 8'd0, 3'd4, 2'b01, 0, 1, 2'b10, 0, 32'h0};

    rst = 1'b1; rready = 1'b1; arvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    repeat (3) @(negedge clk);
    check("rst_arready", {78'b0, arready}, 79'd0);
    check("rst_rvalid", {78'b0, rvalid}, 79'd0);
    check("rst_rlast", {78'b0, rlast}, 79'd0);
    check("rst_mem_rd_en", {78'b0, mem_rd_en}, 79'd0);
    check("rst_busy", {78'b0, busy}, 79'd0);
    check("rst_payload", {rid, rresp, 1'b0, rdata}, 79'd0);
    check("rst_mem_addr", {47'b0, mem_rd_addr}, 79'd0);
    rst = 1'b0;
    @(negedge clk);
    check("release_arready", {78'b0, arready}, 79'd1);

    for (int v = 0; v < 8; v++) begin
      run_burst(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, vecs[v].mode);
      check("vec_beats", 79'(got_q.size()), 79'(vecs[v].exp_beats));
      for (int i = 0; i < got_q.size(); i++)
        check("vec_resp", {77'b0, got_q[i][66:65]}, {77'b0, vecs[v].exp_resp});
      if (got_q.size() > 0) check("vec_last", {78'b0, got_q[got_q.size()-1][64]}, 79'd1);
      check("vec_reads", 79'(got_addr_q.size()), 79'(vecs[v].exp_reads));
      if (vecs[v].exp_reads > 1 && got_addr_q.size() > 1)
        check("vec_addr1", {47'b0, got_addr_q[1]}, {47'b0, vecs[v].exp_a1});
    end

    // Reset asserted while beat 2 sits in RESP: R must drop at once, next burst served normally.
    begin
      int cyc, n;
      arid = 12'd9; araddr = 32'h300; arlen = 8'd3; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      rready = 1'b1; n = 0; cyc = 0;
      while (cyc < 100 && !(rvalid && n == 1)) begin
        if (rvalid) n++;
        @(negedge clk);
        cyc++;
      end
      check("abort_reach_beat2", {78'b0, rvalid}, 79'd1);
      rready = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("abort_rvalid", {78'b0, rvalid}, 79'd0);
      check("abort_busy", {78'b0, busy}, 79'd0);
      check("abort_arready", {78'b0, arready}, 79'd0);
      repeat (3) begin
        @(negedge clk);
        check("abort_hold", {77'b0, rvalid, mem_rd_en}, 79'd0);
      end
      rst = 1'b0;
      rready = 1'b1;
      @(negedge clk);
      check("abort_release_arready", {78'b0, arready}, 79'd1);
      run_burst(12'd13, 32'h0000_0800, 8'd3, 3'd2, 2'b01, 0);
    end

    // Random bursts scored against the reference model.
    for (int t = 0; t < 40; t++) begin
      logic [1:0]  b;
      logic [2:0]  s;
      logic [7:0]  l;
      logic [31:0] a;
      b = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
      s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      a = $urandom;
      if (b == 2'b10) begin
        l = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 16))
                                        : 8'((1 << $urandom_range(1, 4)) - 1);
        a = a & ~((32'd1 << s) - 32'd1);
      end else begin
        l = 8'($urandom_range(0, 12));
      end
      run_burst(12'($urandom), a, l, s, b, $urandom_range(0, 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
